// File: rtl/add_seq_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
package add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int SLICE_W = 4;

    // Bits needed to index nslice slices (ceil(log2(nslice))), never below 1.
    function automatic int slice_idx_w(input int nslice);
        int w;
        int v;
        w = 0;
        v = nslice - 1;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/add_seq_ctrl_nibble_add4.sv
// Combinational 4-bit ripple-carry adder slice made of four full-adder cells.
module nibble_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign co = c[4];

endmodule

// File: rtl/add_seq_ctrl.sv
// Nibble-serial WIDTH-bit add/subtract sequencer. One operation is accepted in
// IDLE, processed LSB nibble first through a single shared 4-bit slice (one
// nibble per clock, carry registered between nibbles), and presented in DONE
// until the consumer takes it.
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_ci,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int KW     = slice_idx_w(NSLICE);
    localparam int MSB    = WIDTH - 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    if (((WIDTH % SLICE_W) != 0) || (WIDTH < SLICE_W)) begin : g_bad_width
        $error("add_seq_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;

    // Bit offset of the current nibble (k * 4); the two zero LSBs encode SLICE_W=4.
    logic [KW+1:0]        base;
    logic [SLICE_W-1:0]   sl_a, sl_b, sl_s;
    logic                 sl_co;
    logic [WIDTH-1:0]     res_full;

    assign base = {k_q, 2'b00};
    assign sl_a = a_q[base +: SLICE_W];
    assign sl_b = b_q[base +: SLICE_W];

    nibble_add4 u_slice (
        .a  (sl_a),
        .b  (sl_b),
        .ci (carry_q),
        .s  (sl_s),
        .co (sl_co)
    );

    // State, operand, carry and result registers; reset discards any partial work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic: capture in IDLE, one nibble per cycle in RUN, hold in DONE.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        sum_d    = sum_q;
        co_d     = co_q;
        ovf_d    = ovf_q;
        // Accumulator with the current slice result merged in; on the last
        // slice this is the complete result.
        res_full = acc_q;
        res_full[base +: SLICE_W] = sl_s;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is A + ~B + ~borrow, so invert at capture time.
                    a_d     = op_a;
                    b_d     = op_sub ? ~op_b : op_b;
                    carry_d = op_sub ? ~op_ci : op_ci;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = res_full;
                carry_d = sl_co;
                k_d     = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = DONE;
                    sum_d   = res_full;
                    co_d    = sl_co;
                    ovf_d   = (a_q[MSB] == b_q[MSB]) && (res_full[MSB] != a_q[MSB]);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign co        = co_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl (WIDTH=16) with an expected-result queue.
module tb_add_seq_ctrl;

    localparam int W      = 16;
    localparam int NSLICE = W / 4;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_ci;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         co;
    logic         ovf;
    logic         busy;

    exp_t sb[$];
    int   n_chk;
    int   n_fail;

    add_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_ci     (op_ci),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Whole-word reference: A + B + ci, or A + ~B + ~borrow for subtraction.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic sub);
        logic [W-1:0] bb;
        logic         cc;
        logic [W:0]   r;
        exp_t         e;
        bb    = sub ? ~b : b;
        cc    = sub ? ~ci : ci;
        r     = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
        e.s   = r[W-1:0];
        e.co  = r[W];
        e.ovf = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation from IDLE, wait for the result, compare against the
    // queued expectation. With hold set, out_ready stays low in DONE.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input logic sub, input exp_t e, input bit hold);
        int   cyc;
        exp_t x;
        op_a      = a;
        op_b      = b;
        op_ci     = ci;
        op_sub    = sub;
        in_valid  = 1'b1;
        out_ready = hold ? 1'b0 : 1'b1;
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        sb.push_back(e);
        // Operands changing after acceptance must not disturb the result.
        op_a   = W'($urandom);
        op_b   = W'($urandom);
        op_ci  = 1'($urandom);
        op_sub = 1'($urandom);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(NSLICE));
        if (out_valid && sb.size() > 0) begin
            x = sb.pop_front();
            chk({tag, "_sum"}, {16'd0, sum}, {16'd0, x.s});
            chk({tag, "_co"}, {31'd0, co}, {31'd0, x.co});
            chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, x.ovf});
        end
        if (!hold) begin
            tick();
            chk({tag, "_back_idle"}, {30'd0, out_valid, in_ready}, 32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t         e;
        logic [W-1:0] ra, rb, held;
        logic         rci, rsub;
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_a      = '0;
        op_b      = '0;
        op_ci     = 1'b0;
        op_sub    = 1'b0;
        tick();
        tick();
        chk("rst_flags", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'h8);
        chk("rst_result", {14'd0, sum, co, ovf}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed vectors with hand-computed expectations.
        e = '{s: 16'h5555, co: 1'b0, ovf: 1'b0};
        run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, e, 1'b0);
        e = '{s: 16'h0000, co: 1'b1, ovf: 1'b0};
        run_op("add_carry_all", 16'hFFFF, 16'h0001, 1'b0, 1'b0, e, 1'b0);
        e = '{s: 16'h0010, co: 1'b0, ovf: 1'b0};
        run_op("add_ci", 16'h000F, 16'h0000, 1'b1, 1'b0, e, 1'b0);
        e = '{s: 16'h8000, co: 1'b0, ovf: 1'b1};
        run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, e, 1'b0);
        e = '{s: 16'h7FFF, co: 1'b1, ovf: 1'b1};
        run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, e, 1'b0);
        e = '{s: 16'hFFFE, co: 1'b0, ovf: 1'b0};
        run_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, e, 1'b0);
        e = '{s: 16'h0001, co: 1'b1, ovf: 1'b0};
        run_op("sub_borrow", 16'h0007, 16'h0005, 1'b1, 1'b1, e, 1'b0);

        // Random operations against the whole-word reference.
        for (int i = 0; i < 6; i++) begin
            ra   = W'($urandom);
            rb   = W'($urandom);
            rci  = 1'($urandom);
            rsub = 1'($urandom);
            run_op("rand", ra, rb, rci, rsub, model(ra, rb, rci, rsub), 1'b0);
        end

        // Backpressure: result held while new requests are presented and ignored.
        e = '{s: 16'h5555, co: 1'b0, ovf: 1'b0};
        run_op("bp", 16'h1234, 16'h4321, 1'b0, 1'b0, e, 1'b1);
        held = sum;
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            op_a     = W'($urandom);
            op_b     = W'($urandom);
            tick();
            chk("bp_hold_flags", {29'd0, out_valid, in_ready, busy}, 32'h5);
            chk("bp_hold_sum", {16'd0, sum}, {16'd0, held});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_flags", {29'd0, out_valid, in_ready, busy}, 32'h2);
        chk("bp_release_sum", {16'd0, sum}, 32'h5555);
        tick();
        chk("bp_no_capture", {31'd0, busy}, 32'd0);

        // Asynchronous reset while slice k=2 is pending.
        op_a     = 16'h1111;
        op_b     = 16'h2222;
        op_ci    = 1'b0;
        op_sub   = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("abort_in_run", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_flags", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'h8);
        chk("abort_result", {14'd0, sum, co, ovf}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_abort_idle", {30'd0, out_valid, in_ready}, 32'd1);
        end
        e = '{s: 16'h0002, co: 1'b0, ovf: 1'b0};
        run_op("post_abort_op", 16'h0001, 16'h0001, 1'b0, 1'b0, e, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
